// File: rtl/dpram_pkg.sv
// Shared constants and clear-sequencer state encoding for the dpram_sync dual-port RAM.
package dpram_pkg;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  localparam int PRIO_A = 0;
  localparam int PRIO_B = 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/dpram_rdpipe.sv
// Read-return pipeline: delays {valid, data} by STAGES registers and holds the last data between pulses.
module dpram_rdpipe #(
  parameter int DW     = 8,
  parameter int STAGES = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_val,
  input  logic [DW-1:0] in_data,
  output logic          val,
  output logic [DW-1:0] dout
);

  generate
    if (STAGES == 0) begin : g_pass
      assign val  = in_val;
      assign dout = in_data;
    end else begin : g_pipe
      logic [STAGES-1:0] v_q;
      logic [DW-1:0]     d_q [STAGES];

      // Data registers only load alongside a valid bit so the output holds its last read value.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_q <= '0;
          for (int i = 0; i < STAGES; i++) begin
            d_q[i] <= '0;
          end
        end else begin
          v_q[0] <= in_val;
          if (in_val) begin
            d_q[0] <= in_data;
          end
          for (int i = 1; i < STAGES; i++) begin
            v_q[i] <= v_q[i-1];
            if (v_q[i-1]) begin
              d_q[i] <= d_q[i-1];
            end
          end
        end
      end

      assign val  = v_q[STAGES-1];
      assign dout = d_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/dpram_sync.sv
// Single-clock true dual-port RAM with post-reset clear sequencer, write-collision priority,
// selectable read-during-write behaviour and a configurable read latency per port.
module dpram_sync
  import dpram_pkg::*;
#(
  parameter int          DW        = 8,
  parameter int          AW        = 3,
  parameter int          RD_LAT    = 2,
  parameter logic [DW-1:0] INIT_VAL = '0,
  parameter int          COLL_PRIO = 0,
  parameter int          RDW_MODE  = 0
) (
  input  logic          clk,
  input  logic          rst,
  output logic          init_busy,
  input  logic          ena,
  input  logic          wea,
  input  logic [AW-1:0] addra,
  input  logic [DW-1:0] dina,
  output logic [DW-1:0] douta,
  output logic          vala,
  input  logic          enb,
  input  logic          web,
  input  logic [AW-1:0] addrb,
  input  logic [DW-1:0] dinb,
  output logic [DW-1:0] doutb,
  output logic          valb,
  output logic          coll
);

  localparam int          DEPTH    = 2**AW;
  localparam logic [AW:0] LAST_PTR = (AW+1)'(DEPTH - 1);

  state_t        state, state_next;
  logic [AW:0]   ptr, ptr_next;
  logic          clr_we;
  logic          run;
  logic          wr_a, wr_b, rd_a, rd_b;
  logic          same_addr, wcoll;
  logic          keep_a, keep_b;
  logic [DW-1:0] rdata_a, rdata_b;
  logic          s0_val_a, s0_val_b;
  logic [DW-1:0] s0_dat_a, s0_dat_b;
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_CLEAR;
      ptr       <= '0;
      init_busy <= 1'b1;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      init_busy <= (state_next == ST_CLEAR);
    end
  end

  // CLEAR writes one word per cycle and hands over to RUN after the last address.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    clr_we     = 1'b0;
    case (state)
      ST_CLEAR: begin
        clr_we   = 1'b1;
        ptr_next = ptr + 1'b1;
        if (ptr == LAST_PTR) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        state_next = ST_RUN;
      end
    endcase
  end

  assign run       = (state == ST_RUN);
  assign wr_a      = run && ena && (wea == OP_WRITE);
  assign wr_b      = run && enb && (web == OP_WRITE);
  assign rd_a      = run && ena && (wea == OP_READ);
  assign rd_b      = run && enb && (web == OP_READ);
  assign same_addr = (addra == addrb);
  assign wcoll     = wr_a && wr_b && same_addr;
  assign keep_a    = wr_a && !(wcoll && (COLL_PRIO == PRIO_B));
  assign keep_b    = wr_b && !(wcoll && (COLL_PRIO == PRIO_A));

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[ptr[AW-1:0]] <= INIT_VAL;
    end
    if (keep_a) begin
      mem[addra] <= dina;
    end
    if (keep_b) begin
      mem[addrb] <= dinb;
    end
  end

  // A reading port can only clash with the other port's write; write-first forwards that data.
  always_comb begin
    rdata_a = mem[addra];
    rdata_b = mem[addrb];
    if ((RDW_MODE == RDW_WRITE_FIRST) && keep_b && same_addr) begin
      rdata_a = dinb;
    end
    if ((RDW_MODE == RDW_WRITE_FIRST) && keep_a && same_addr) begin
      rdata_b = dina;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_val_a <= 1'b0;
      s0_val_b <= 1'b0;
      s0_dat_a <= '0;
      s0_dat_b <= '0;
      coll     <= 1'b0;
    end else begin
      s0_val_a <= rd_a;
      s0_val_b <= rd_b;
      coll     <= wcoll;
      if (rd_a) begin
        s0_dat_a <= rdata_a;
      end
      if (rd_b) begin
        s0_dat_b <= rdata_b;
      end
    end
  end

  dpram_rdpipe #(
    .DW     (DW),
    .STAGES (RD_LAT - 1)
  ) u_pipe_a (
    .clk     (clk),
    .rst     (rst),
    .in_val  (s0_val_a),
    .in_data (s0_dat_a),
    .val     (vala),
    .dout    (douta)
  );

  dpram_rdpipe #(
    .DW     (DW),
    .STAGES (RD_LAT - 1)
  ) u_pipe_b (
    .clk     (clk),
    .rst     (rst),
    .in_val  (s0_val_b),
    .in_data (s0_dat_b),
    .val     (valb),
    .dout    (doutb)
  );

endmodule

// File: tb/tb_dpram_sync.sv
// Drives three differently configured dpram_sync instances with shared stimulus and checks
// every output each cycle against a behavioural memory model with a response schedule.
module tb_dpram_sync;

  localparam int DEPTH = 8;
  localparam int NI    = 3;

  logic       clk, rst;
  logic       ena, wea, enb, web;
  logic [2:0] addra, addrb;
  logic [7:0] dina, dinb;

  logic       init_busy_o [NI];
  logic [7:0] douta_o [NI];
  logic [7:0] doutb_o [NI];
  logic       vala_o [NI];
  logic       valb_o [NI];
  logic       coll_o [NI];

  logic [7:0] mem_m [NI][DEPTH];
  logic       sched_v [NI][2][8];
  logic [7:0] sched_d [NI][2][8];
  logic [7:0] last_d [NI][2];
  logic       coll_e [NI];
  int         busy_left;
  int         cyc;
  int         n_checks;
  int         n_fail;

  function automatic int cfgLat(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 4;
  endfunction

  function automatic int cfgPrio(input int k);
    return (k == 0) ? 0 : 1;
  endfunction

  function automatic int cfgRdw(input int k);
    return (k == 1) ? 1 : 0;
  endfunction

  function automatic logic [7:0] cfgInit(input int k);
    return (k == 2) ? 8'h5A : 8'hA5;
  endfunction

  dpram_sync #(.DW(8), .AW(3), .RD_LAT(2), .INIT_VAL(8'hA5), .COLL_PRIO(0), .RDW_MODE(0)) u_dut0 (
    .clk(clk), .rst(rst), .init_busy(init_busy_o[0]),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta_o[0]), .vala(vala_o[0]),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb_o[0]), .valb(valb_o[0]),
    .coll(coll_o[0])
  );

  dpram_sync #(.DW(8), .AW(3), .RD_LAT(1), .INIT_VAL(8'hA5), .COLL_PRIO(1), .RDW_MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .init_busy(init_busy_o[1]),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta_o[1]), .vala(vala_o[1]),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb_o[1]), .valb(valb_o[1]),
    .coll(coll_o[1])
  );

  dpram_sync #(.DW(8), .AW(3), .RD_LAT(4), .INIT_VAL(8'h5A), .COLL_PRIO(1), .RDW_MODE(0)) u_dut2 (
    .clk(clk), .rst(rst), .init_busy(init_busy_o[2]),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta_o[2]), .vala(vala_o[2]),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb_o[2]), .valb(valb_o[2]),
    .coll(coll_o[2])
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic modelReset();
    busy_left = DEPTH;
    for (int k = 0; k < NI; k++) begin
      coll_e[k] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        last_d[k][p] = 8'h00;
        for (int s = 0; s < 8; s++) begin
          sched_v[k][p][s] = 1'b0;
          sched_d[k][p][s] = 8'h00;
        end
      end
    end
  endtask

  task automatic scheduleRead(input int k, input int p, input logic [7:0] d);
    int slot;
    slot = (cyc + cfgLat(k) - 1) % 8;
    sched_v[k][p][slot] = 1'b1;
    sched_d[k][p][slot] = d;
  endtask

  // Applies what the memory does at one rising edge, given the inputs currently presented.
  task automatic modelEdge();
    logic [7:0] d;
    cyc++;
    if (rst) return;
    if (busy_left > 0) begin
      for (int k = 0; k < NI; k++) begin
        mem_m[k][DEPTH - busy_left] = cfgInit(k);
        coll_e[k] = 1'b0;
      end
      busy_left--;
      return;
    end
    for (int k = 0; k < NI; k++) begin
      if (ena && !wea) begin
        d = mem_m[k][addra];
        if (cfgRdw(k) == 1 && enb && web && addrb == addra) d = dinb;
        scheduleRead(k, 0, d);
      end
      if (enb && !web) begin
        d = mem_m[k][addrb];
        if (cfgRdw(k) == 1 && ena && wea && addra == addrb) d = dina;
        scheduleRead(k, 1, d);
      end
      coll_e[k] = ena && wea && enb && web && (addra == addrb);
      if (coll_e[k]) begin
        mem_m[k][addra] = (cfgPrio(k) == 1) ? dinb : dina;
      end else begin
        if (ena && wea) mem_m[k][addra] = dina;
        if (enb && web) mem_m[k][addrb] = dinb;
      end
    end
  endtask

  task automatic checkAll();
    int   slot;
    logic ev;
    slot = cyc % 8;
    for (int k = 0; k < NI; k++) begin
      checkOutput($sformatf("i%0d init_busy", k), 32'(init_busy_o[k]), 32'(busy_left > 0));
      for (int p = 0; p < 2; p++) begin
        ev = sched_v[k][p][slot];
        if (ev) last_d[k][p] = sched_d[k][p][slot];
        sched_v[k][p][slot] = 1'b0;
        if (p == 0) begin
          checkOutput($sformatf("i%0d vala", k), 32'(vala_o[k]), 32'(ev));
          checkOutput($sformatf("i%0d douta", k), 32'(douta_o[k]), 32'(last_d[k][0]));
        end else begin
          checkOutput($sformatf("i%0d valb", k), 32'(valb_o[k]), 32'(ev));
          checkOutput($sformatf("i%0d doutb", k), 32'(doutb_o[k]), 32'(last_d[k][1]));
        end
      end
      checkOutput($sformatf("i%0d coll", k), 32'(coll_o[k]), 32'(coll_e[k]));
    end
  endtask

  // Presents one request pair for a cycle, then checks outputs on the following falling edge.
  task automatic applyStimulus(input logic ea, input logic wa, input logic [2:0] aa, input logic [7:0] da,
                               input logic eb, input logic wb, input logic [2:0] ab, input logic [7:0] db);
    ena = ea; wea = wa; addra = aa; dina = da;
    enb = eb; web = wb; addrb = ab; dinb = db;
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkAll();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
    end
  endtask

  task automatic randomCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom));
    end
  endtask

  // Asserts reset mid-cycle so the asynchronous clear of the outputs is visible before any edge.
  task automatic doReset(input int hold);
    #2 rst = 1'b1;
    modelReset();
    #1 checkAll();
    ena = 1'b0; wea = 1'b0; enb = 1'b0; web = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      modelEdge();
      @(negedge clk);
      checkAll();
    end
    rst = 1'b0;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1;
    ena = 1'b0; wea = 1'b0; addra = 3'd0; dina = 8'h00;
    enb = 1'b0; web = 1'b0; addrb = 3'd0; dinb = 8'h00;
    cyc = 0; n_checks = 0; n_fail = 0;
    for (int k = 0; k < NI; k++) begin
      for (int a = 0; a < DEPTH; a++) mem_m[k][a] = 8'h00;
    end
    modelReset();
    @(negedge clk);
    doReset(3);

    $display("[TB] requests during clear, then read back every word");
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 3'(i), 8'h00, 1'b1, 1'b1, 3'(i), 8'hEE);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 3'(i), 8'h00, 1'b1, 1'b0, 3'(7 - i), 8'h00);
    idleCycles(5);

    $display("[TB] write on A then read on B");
    applyStimulus(1'b1, 1'b1, 3'd5, 8'h3C, 1'b0, 1'b0, 3'd0, 8'h00);
    applyStimulus(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd5, 8'h00);
    idleCycles(5);

    $display("[TB] same-address write collision");
    applyStimulus(1'b1, 1'b1, 3'd2, 8'h11, 1'b1, 1'b1, 3'd2, 8'h22);
    applyStimulus(1'b1, 1'b0, 3'd2, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
    idleCycles(5);

    $display("[TB] read during write from the other port");
    applyStimulus(1'b1, 1'b1, 3'd4, 8'h07, 1'b0, 1'b0, 3'd0, 8'h00);
    applyStimulus(1'b1, 1'b1, 3'd4, 8'h99, 1'b1, 1'b0, 3'd4, 8'h00);
    applyStimulus(1'b1, 1'b0, 3'd3, 8'h00, 1'b1, 1'b1, 3'd3, 8'h6D);
    idleCycles(5);

    $display("[TB] back-to-back reads 1, 6, 1 and hold between pulses");
    applyStimulus(1'b1, 1'b1, 3'd6, 8'hC3, 1'b1, 1'b1, 3'd1, 8'h18);
    applyStimulus(1'b1, 1'b0, 3'd1, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
    applyStimulus(1'b1, 1'b0, 3'd6, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
    applyStimulus(1'b1, 1'b0, 3'd1, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
    idleCycles(7);

    $display("[TB] randomized traffic");
    randomCycles(400);

    $display("[TB] reset with reads in flight");
    applyStimulus(1'b1, 1'b0, 3'd3, 8'h00, 1'b1, 1'b0, 3'd5, 8'h00);
    applyStimulus(1'b1, 1'b0, 3'd4, 8'h00, 1'b1, 1'b0, 3'd6, 8'h00);
    doReset(2);

    $display("[TB] reset during clear");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 3'(i), 8'h00, 1'b1, 1'b0, 3'(i), 8'h00);
    doReset(1);
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 3'(i), 8'h00, 1'b1, 1'b0, 3'(i + 3), 8'h00);
    randomCycles(200);
    idleCycles(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
